// File: rtl/romulus_pkg.sv
// Shared types and constants for the Romulus-N mode controller.
// Domain bytes, stream type codes and the SKINNY round-constant step.
package romulus_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_KEY,
    S_AD_S,
    S_AD_T,
    S_NONCE,
    S_MSG,
    S_ENC,
    S_RESTORE,
    S_TAG
  } state_e;

  localparam logic [7:0] DOM_AD       = 8'h08;
  localparam logic [7:0] DOM_AD_LAST  = 8'h18;
  localparam logic [7:0] DOM_AD_PAD   = 8'h1A;
  localparam logic [7:0] DOM_MSG      = 8'h04;
  localparam logic [7:0] DOM_MSG_LAST = 8'h14;
  localparam logic [7:0] DOM_MSG_PAD  = 8'h15;

  localparam logic [5:0] RC_INIT = 6'h01;

  localparam logic [1:0] BT_NONCE = 2'b00;
  localparam logic [1:0] BT_AD    = 2'b01;
  localparam logic [1:0] BT_MSG   = 2'b10;

  function automatic logic [5:0] rc_step(input logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/romulus_rc_lfsr2.sv
// SKINNY round-constant LFSR advancing two rounds per enabled cycle.
// rc_o serves round 2k, rc2_o round 2k+1.
module romulus_rc_lfsr2
  import romulus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       load_i,
  output logic [5:0] rc_o,
  output logic [5:0] rc2_o
);

  logic [5:0] rc_q;

  always_ff @(posedge clk) begin
    if (rst || load_i) begin
      rc_q <= RC_INIT;
    end else if (en_i) begin
      rc_q <= rc_step(rc_step(rc_q));
    end
  end

  assign rc_o  = rc_q;
  assign rc2_o = rc_step(rc_q);

endmodule

// File: rtl/romulusn_mode_ctrl.sv
// Romulus-N control FSM: sequences key/AD/nonce/message/tag transfers
// and SKINNY calls, decoding datapath strobes from state and handshake.
module romulusn_mode_ctrl
  import romulus_pkg::*;
#(
  parameter int ROUND_CYCLES = 20,
  parameter int WORDS        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dec_op,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       bdi_valid,
  output logic       bdi_ready,
  input  logic [1:0] bdi_type,
  input  logic       bdi_last,
  input  logic       bdi_pad,
  output logic       bdo_valid,
  input  logic       bdo_ready,
  output logic       done,
  output logic       srst,
  output logic       senc,
  output logic       sse,
  output logic       xrst,
  output logic       xenc,
  output logic       xse,
  output logic       yrst,
  output logic       yenc,
  output logic       yse,
  output logic       zrst,
  output logic       zenc,
  output logic       zse,
  output logic       erst,
  output logic       correct_cnt,
  output logic       tk1s,
  output logic [5:0] constant,
  output logic [5:0] constant2,
  output logic [7:0] domain,
  output logic [3:0] decrypt
);

  localparam logic [1:0] WLAST = 2'(WORDS - 1);
  localparam logic [4:0] KLAST = 5'(ROUND_CYCLES - 1);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  logic [7:0] dom_q, dom_d;
  logic       done_q, done_d;
  logic [1:0] wcnt_q;
  logic [4:0] k_q;
  logic       dec_q, last_q, pad_q;
  logic       acc, wlast, in_enc, blk_first;

  assign wlast     = (wcnt_q == WLAST);
  assign in_enc    = (state_q == S_ENC);
  assign blk_first = acc && bdi_ready && (wcnt_q == 2'd0);

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    dom_d       = dom_q;
    done_d      = 1'b0;
    acc         = 1'b0;
    srst        = 1'b0;
    senc        = 1'b0;
    sse         = 1'b0;
    xrst        = 1'b0;
    xenc        = 1'b0;
    xse         = 1'b0;
    yrst        = 1'b0;
    yenc        = 1'b0;
    yse         = 1'b0;
    zrst        = 1'b0;
    zenc        = 1'b0;
    zse         = 1'b0;
    erst        = 1'b0;
    correct_cnt = 1'b0;
    tk1s        = 1'b0;
    key_ready   = 1'b0;
    bdi_ready   = 1'b0;
    bdo_valid   = 1'b0;
    decrypt     = 4'h0;
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            srst    = 1'b1;
            zrst    = 1'b1;
            erst    = 1'b1;
            state_d = S_LD_KEY;
          end
        end
        S_LD_KEY: begin
          key_ready = 1'b1;
          acc       = key_valid;
          xse       = acc;
          if (acc && wlast) state_d = S_AD_S;
        end
        S_AD_S: begin
          // A nonce at the head of AD means empty AD: run it unconsumed
          if (wcnt_q == 2'd0 && bdi_valid
              && bdi_type == BT_NONCE) begin
            dom_d   = DOM_AD_PAD;
            ret_d   = S_NONCE;
            state_d = S_ENC;
          end else begin
            bdi_ready = 1'b1;
            acc       = bdi_valid;
            sse       = acc;
            if (acc && wlast) begin
              if (last_q) begin
                dom_d   = pad_q ? DOM_AD_PAD : DOM_AD_LAST;
                ret_d   = S_NONCE;
                state_d = S_ENC;
              end else begin
                state_d = S_AD_T;
              end
            end
          end
        end
        S_AD_T: begin
          bdi_ready = 1'b1;
          tk1s      = 1'b1;
          acc       = bdi_valid;
          yse       = acc;
          if (acc && wlast) begin
            dom_d   = last_q ? DOM_AD_LAST : DOM_AD;
            ret_d   = last_q ? S_NONCE : S_AD_S;
            state_d = S_ENC;
          end
        end
        S_NONCE: begin
          bdi_ready = 1'b1;
          acc       = bdi_valid;
          yse       = acc;
          if (acc && wlast) state_d = S_MSG;
        end
        S_MSG: begin
          bdi_ready = bdo_ready;
          bdo_valid = bdi_valid;
          acc       = bdi_valid && bdo_ready;
          sse       = acc;
          decrypt   = {4{dec_q}};
          if (acc && wlast) begin
            if (last_q) begin
              dom_d = pad_q ? DOM_MSG_PAD : DOM_MSG_LAST;
            end else begin
              dom_d = DOM_MSG;
            end
            ret_d   = last_q ? S_TAG : S_MSG;
            state_d = S_ENC;
          end
        end
        S_ENC: begin
          senc = 1'b1;
          xenc = 1'b1;
          yenc = 1'b1;
          zenc = 1'b1;
          if (k_q == KLAST) state_d = S_RESTORE;
        end
        S_RESTORE: begin
          xrst        = 1'b1;
          yrst        = 1'b1;
          zrst        = 1'b1;
          correct_cnt = 1'b1;
          state_d     = ret_q;
        end
        S_TAG: begin
          bdo_valid = 1'b1;
          acc       = bdo_ready;
          sse       = acc;
          if (acc && wlast) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      dom_q   <= 8'h00;
      done_q  <= 1'b0;
      wcnt_q  <= 2'd0;
      k_q     <= 5'd0;
      dec_q   <= 1'b0;
      last_q  <= 1'b0;
      pad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      if (state_q == S_IDLE && start) dec_q <= dec_op;
      if (acc) wcnt_q <= wcnt_q + 2'd1;
      if (in_enc) k_q <= (k_q == KLAST) ? 5'd0 : k_q + 5'd1;
      if (blk_first) begin
        last_q <= bdi_last;
        pad_q  <= bdi_pad;
      end
    end
  end

  romulus_rc_lfsr2 u_rc (
    .clk   (clk),
    .rst   (rst),
    .en_i  (in_enc),
    .load_i(in_enc && k_q == KLAST),
    .rc_o  (constant),
    .rc2_o (constant2)
  );

  assign done   = done_q;
  assign domain = dom_q;

endmodule

// File: tb/tb_romulusn_mode_ctrl.sv
// Randomized scoreboard bench for romulusn_mode_ctrl: a protocol-level
// model queues the expected strobe events, a monitor pops and compares.
module tb_romulusn_mode_ctrl;

  logic clk, rst, start, dec_op;
  logic key_valid, key_ready, bdi_valid, bdi_ready;
  logic [1:0] bdi_type;
  logic bdi_last, bdi_pad, bdo_valid, bdo_ready, done;
  logic srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse;
  logic zrst, zenc, zse, erst, correct_cnt, tk1s;
  logic [5:0] constant, constant2;
  logic [7:0] domain;
  logic [3:0] decrypt;

  romulusn_mode_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .dec_op(dec_op),
    .key_valid(key_valid), .key_ready(key_ready),
    .bdi_valid(bdi_valid), .bdi_ready(bdi_ready),
    .bdi_type(bdi_type), .bdi_last(bdi_last), .bdi_pad(bdi_pad),
    .bdo_valid(bdo_valid), .bdo_ready(bdo_ready), .done(done),
    .srst(srst), .senc(senc), .sse(sse),
    .xrst(xrst), .xenc(xenc), .xse(xse),
    .yrst(yrst), .yenc(yenc), .yse(yse),
    .zrst(zrst), .zenc(zenc), .zse(zse), .erst(erst),
    .correct_cnt(correct_cnt), .tk1s(tk1s),
    .constant(constant), .constant2(constant2),
    .domain(domain), .decrypt(decrypt)
  );

  typedef struct packed {
    logic srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse;
    logic zrst, zenc, zse, erst, cc, tk1s;
    logic kr, br, bv, dn;
    logic [5:0] c1, c2;
    logic [7:0] dom;
    logic [3:0] dec;
  } obs_t;

  // Published SKINNY-128 round constants, rounds 0..39
  logic [5:0] rc_tab [40] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B,
    6'h37, 6'h2F, 6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E,
    6'h1D, 6'h3A, 6'h35, 6'h2B, 6'h16, 6'h2C, 6'h18, 6'h30,
    6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E, 6'h1C, 6'h38,
    6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
  };

  obs_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int ev_idx = 0;
  int bp_mode = 0;
  logic [7:0] cur_dom = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected handshake", nm);
  endtask

  function automatic obs_t dut_obs();
    return {srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse,
            zrst, zenc, zse, erst, correct_cnt, tk1s,
            key_ready, bdi_ready, bdo_valid, done,
            constant, constant2, domain, decrypt};
  endfunction

  function automatic obs_t base();
    obs_t o;
    o = '0;
    o.c1 = 6'h01;
    o.c2 = 6'h03;
    o.dom = cur_dom;
    return o;
  endfunction

  always @(negedge clk) begin
    obs_t a, e;
    if (!rst) begin
      a = dut_obs();
      if (srst | senc | sse | xrst | xenc | xse | yrst | yenc | yse
          | zrst | zenc | zse | erst | correct_cnt | done) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: got %h expected none", a);
        end else begin
          e = q.pop_front();
          chk($sformatf("event%0d", ev_idx), 64'(a), 64'(e));
        end
        ev_idx++;
      end
    end
  end

  initial begin
    bdo_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0: bdo_ready = 1'b1;
        1: bdo_ready = ~bdo_ready;
        default: bdo_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- reference model ----------------
  task automatic push_n(input obs_t o, input int n);
    for (int i = 0; i < n; i++) q.push_back(o);
  endtask

  task automatic push_enc(input logic [7:0] d, input int n,
                          input bit restore);
    obs_t o;
    cur_dom = d;
    for (int k = 0; k < n; k++) begin
      o = base();
      o.senc = 1; o.xenc = 1; o.yenc = 1; o.zenc = 1;
      o.c1 = rc_tab[2*k];
      o.c2 = rc_tab[2*k+1];
      q.push_back(o);
    end
    if (restore) begin
      o = base();
      o.xrst = 1; o.yrst = 1; o.zrst = 1; o.cc = 1;
      q.push_back(o);
    end
  endtask

  task automatic model_prefix();
    obs_t o;
    o = base();
    o.srst = 1; o.zrst = 1; o.erst = 1;
    q.push_back(o);
    o = base();
    o.xse = 1; o.kr = 1;
    push_n(o, 4);
  endtask

  task automatic model_op(input bit dec, input int n_ad,
                          input bit ad_pad, input int n_msg,
                          input bit msg_pad);
    obs_t o;
    bit last;
    model_prefix();
    if (n_ad == 0) push_enc(8'h1A, 20, 1);
    for (int i = 0; i < n_ad; i++) begin
      last = (i == n_ad - 1);
      o = base();
      o.br = 1;
      if (i % 2 == 0) begin
        o.sse = 1;
        push_n(o, 4);
        if (last) push_enc(ad_pad ? 8'h1A : 8'h18, 20, 1);
      end else begin
        o.yse = 1; o.tk1s = 1;
        push_n(o, 4);
        push_enc(last ? 8'h18 : 8'h08, 20, 1);
      end
    end
    o = base();
    o.yse = 1; o.br = 1;
    push_n(o, 4);
    for (int j = 0; j < n_msg; j++) begin
      last = (j == n_msg - 1);
      o = base();
      o.sse = 1; o.br = 1; o.bv = 1; o.dec = {4{dec}};
      push_n(o, 4);
      if (last) push_enc(msg_pad ? 8'h15 : 8'h14, 20, 1);
      else push_enc(8'h04, 20, 1);
    end
    o = base();
    o.sse = 1; o.bv = 1;
    push_n(o, 4);
    o = base();
    o.dn = 1;
    q.push_back(o);
  endtask

  // ---------------- drivers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input bit is_bdi);
    int t;
    t = 0;
    if (is_bdi) bdi_valid = 1'b1;
    else key_valid = 1'b1;
    @(negedge clk);
    while (!(is_bdi ? bdi_ready : key_ready)) begin
      t++;
      if (t > 200) begin
        tmo(is_bdi ? "bdi_word" : "key_word");
        break;
      end
      @(negedge clk);
    end
    cyc();
    key_valid = 1'b0;
    bdi_valid = 1'b0;
  endtask

  task automatic send_block(input logic [1:0] t, input bit l,
                            input bit p);
    bdi_type = t;
    bdi_last = l;
    bdi_pad = p & l;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 1)) cyc();
      push_word(1'b1);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while (!done) begin
      t++;
      if (t > 400) begin
        tmo("done");
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input bit dec, input int n_ad, input bit ad_pad,
                        input int n_msg, input bit msg_pad,
                        input int bp);
    model_op(dec, n_ad, ad_pad, n_msg, msg_pad);
    bp_mode = 0;
    dec_op = dec;
    start = 1'b1;
    cyc();
    start = 1'b0;
    dec_op = 1'b0;
    for (int i = 0; i < 4; i++) push_word(1'b0);
    for (int i = 0; i < n_ad; i++)
      send_block(2'b01, i == n_ad - 1, ad_pad);
    send_block(2'b00, 1'b1, 1'b0);
    bp_mode = bp;
    for (int j = 0; j < n_msg; j++)
      send_block(2'b10, j == n_msg - 1, msg_pad);
    wait_done();
    bp_mode = 0;
    cyc();
    chk("queue_drained", 64'(q.size()), 64'd0);
  endtask

  task automatic reset_mid_enc();
    int t;
    int n_enc;
    obs_t a;
    model_prefix();
    push_enc(8'h1A, 10, 0);
    dec_op = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) push_word(1'b0);
    bdi_type = 2'b00;
    bdi_last = 1'b1;
    bdi_valid = 1'b1;
    t = 0;
    n_enc = 0;
    while (n_enc < 10) begin
      @(negedge clk);
      if (senc) n_enc++;
      t++;
      if (t > 200) begin
        tmo("enc_cycles");
        break;
      end
    end
    cyc();
    rst = 1'b1;
    @(negedge clk);
    a = dut_obs();
    chk("rst_cycle_strobes", 64'(a[42:24]), 64'd0);
    chk("rst_queue_drained", 64'(q.size()), 64'd0);
    cyc();
    rst = 1'b0;
    bdi_valid = 1'b0;
    cur_dom = 8'h00;
    @(negedge clk);
    chk("after_rst_idle", 64'(dut_obs()), 64'(base()));
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dec_op = 1'b0;
    key_valid = 1'b0;
    bdi_valid = 1'b0;
    bdi_type = 2'b01;
    bdi_last = 1'b0;
    bdi_pad = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_idle", 64'(dut_obs()), 64'(base()));
    cyc();
    run_op(1'b0, 1, 1'b0, 1, 1'b1, 0);
    run_op(1'b1, 0, 1'b0, 2, 1'b0, 0);
    run_op(1'b0, 2, 1'b1, 2, 1'b1, 1);
    reset_mid_enc();
    run_op(1'b1, 3, 1'b0, 1, 1'b0, 0);
    for (int r = 0; r < 6; r++) begin
      run_op(1'($urandom_range(0, 1)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), $urandom_range(1, 3),
             1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
